// File: rtl/instr_fetch_buffer.sv
// Prefetching instruction-fetch front end: issues sequential fetches, queues
// in-order responses with their PCs, and flushes on branch/jump redirect.
module instr_fetch_buffer #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0,
    parameter logic [31:0] PC_STEP         = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] discard_q, discard_d;
    logic [31:0]   mem_pc_q   [DEPTH];
    logic [31:0]   mem_pc_d   [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [31:0]   mem_data_d [DEPTH];

    logic credit_ok;
    logic accept;
    logic rsp_take;
    logic push;
    logic pop;

    // Queued plus in-flight words never exceed DEPTH, so a push always has room.
    assign credit_ok = ((32'(count_q) + 32'(outstanding_q)) < DEPTH) &&
                       (32'(outstanding_q) < MAX_OUTSTANDING);

    assign req_valid   = reset && !redirect_valid && credit_ok;
    assign req_addr    = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instruction = instr_valid ? mem_data_q[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q]   : '0;

    assign accept   = req_valid && req_ready;
    assign rsp_take = rsp_valid && (outstanding_q != '0);
    assign push     = rsp_take && (discard_q == '0) && !redirect_valid;
    assign pop      = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        discard_d     = discard_q;
        mem_pc_d      = mem_pc_q;
        mem_data_d    = mem_data_q;
        outstanding_d = outstanding_q;

        if (accept) begin
            outstanding_d = outstanding_d + OW'(1);
        end
        if (rsp_take) begin
            outstanding_d = outstanding_d - OW'(1);
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // Every fetch still in flight after this edge belongs to the old path.
            discard_d  = outstanding_d;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (rsp_take && (discard_q != '0)) begin
                discard_d = discard_q - OW'(1);
            end
            if (push) begin
                mem_pc_d[wr_ptr_q]   = rsp_pc_q;
                mem_data_d[wr_ptr_q] = rsp_data;
                wr_ptr_d             = wr_ptr_q + PW'(1);
                rsp_pc_d             = rsp_pc_q + PC_STEP;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Storage needs no reset: outputs are gated by count_q.
    always_ff @(posedge clk) begin
        mem_pc_q   <= mem_pc_d;
        mem_data_q <= mem_data_d;
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Randomized scoreboard bench for instr_fetch_buffer with an epoch-based
// reference model of fetch paths and an in-order memory model.
module tb_instr_fetch_buffer;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAXO    = 2;
    localparam int unsigned TOTAL   = 2600;
    localparam int unsigned WRAP_C  = 1000;
    localparam int unsigned STRAY_C = 1500;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    instr_fetch_buffer #(
        .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO),
        .RESET_PC(32'h0),
        .PC_STEP(32'd4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .instruction(instruction),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int unsigned epoch;
        int unsigned due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ins_t;

    req_t        pend[$];
    ins_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned epoch    = 0;
    int unsigned cyc      = 0;
    int unsigned last_due = 0;
    logic [31:0] next_addr = 32'h0;
    bit          popped_now = 1'b0;
    bit          rsp_from_mem = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: compares the presented head with the scoreboard each cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            popped_now = 1'b0;
            if (cyc >= 1) begin
                if (instr_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL spurious_instr: got pc %h data %h expected none (cycle %0d)",
                                 instr_pc, instruction, cyc);
                    end else begin
                        check("instr_pc", instr_pc, exp_q[0].pc);
                        check("instruction", instruction, exp_q[0].data);
                        if (reset && instr_ready && !redirect_valid) begin
                            void'(exp_q.pop_front());
                            popped_now = 1'b1;
                        end
                    end
                end else begin
                    check("empty_instruction", instruction, 32'h0);
                    check("empty_instr_pc", instr_pc, 32'h0);
                end
            end
        end
    end

    // Stimulus, memory model and reference model.
    initial begin
        reset          = 1'b0;
        req_ready      = 1'b1;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        for (cyc = 0; cyc < TOTAL + 1; cyc++) begin
            int unsigned seg;
            int unsigned r;
            logic [31:0] rp;
            bit          drain;
            bit          stray;
            logic        exp_rv;
            int unsigned exp_count;

            @(negedge clk);
            seg   = (cyc / 256) % 4;
            drain = (cyc >= TOTAL - 40);
            stray = (cyc > STRAY_C) && (cyc <= STRAY_C + 3);

            reset = !((cyc < 2) || (cyc == STRAY_C) ||
                      ((cyc > 300) && !drain && ($urandom_range(0, 499) == 0)));

            rp = $urandom;
            rp[1:0] = 2'b00;
            r = $urandom_range(0, 3);
            if (r == 0) rp = 32'hFFFF_FFF8;
            else if (r == 1) rp = 32'hFFFF_FFFC;
            redirect_pc    = rp;
            redirect_valid = (seg == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);

            case (seg)
                0: begin req_ready = 1'b1; instr_ready = 1'b1; end
                1: begin req_ready = 1'b1; instr_ready = ((cyc % 256) >= 128); end
                2: begin req_ready = $urandom_range(0, 1) == 1; instr_ready = $urandom_range(0, 1) == 1; end
                default: begin req_ready = $urandom_range(0, 3) != 0; instr_ready = $urandom_range(0, 2) != 0; end
            endcase

            if (cyc == WRAP_C) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'hFFFF_FFFC;
            end else if ((cyc > WRAP_C) && (cyc <= WRAP_C + 10)) begin
                redirect_valid = 1'b0;
                reset          = 1'b1;
                req_ready      = 1'b1;
            end
            if (stray) begin
                redirect_valid = 1'b0;
                req_ready      = 1'b0;
            end
            if (drain) begin
                redirect_valid = 1'b0;
                req_ready      = 1'b0;
                instr_ready    = 1'b1;
            end

            rsp_from_mem = (pend.size() > 0) && (pend[0].due <= cyc);
            if (rsp_from_mem) begin
                rsp_valid = 1'b1;
                rsp_data  = word_of(pend[0].addr);
            end else if (cyc == STRAY_C + 1) begin
                rsp_valid = 1'b1;
                rsp_data  = 32'hDEAD_BEEF;
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = $urandom;
            end

            #3;
            if ((cyc == STRAY_C + 2) || (cyc == STRAY_C + 3)) begin
                check("stray_rsp_ignored", 32'(instr_valid), 32'h0);
            end
            if (cyc == TOTAL) begin
                check("leftover_expected", 32'(exp_q.size()), 32'h0);
                check("leftover_pending", 32'(pend.size()), 32'h0);
            end

            exp_count = exp_q.size() + (popped_now ? 1 : 0);
            exp_rv = reset && !redirect_valid &&
                     ((exp_count + pend.size()) < DEPTH) && (pend.size() < MAXO);
            check("req_valid", 32'(req_valid), 32'(exp_rv));

            if (rsp_from_mem) begin
                req_t h;
                h = pend.pop_front();
                if (reset && !redirect_valid && (h.epoch == epoch)) begin
                    ins_t e;
                    e.pc   = h.pc;
                    e.data = word_of(h.pc);
                    exp_q.push_back(e);
                end
            end

            if (req_valid && req_ready) begin
                req_t n;
                int unsigned lat;
                check("req_addr", req_addr, next_addr);
                lat = (seg == 0) ? 1 : $urandom_range(1, 4);
                n.addr  = req_addr;
                n.pc    = next_addr;
                n.epoch = epoch;
                n.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                last_due = n.due;
                pend.push_back(n);
                next_addr = next_addr + 32'd4;
            end

            if (!reset) begin
                pend.delete();
                exp_q.delete();
                epoch++;
                next_addr = 32'h0;
            end else if (redirect_valid) begin
                exp_q.delete();
                epoch++;
                next_addr = redirect_pc;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
